// File: rtl/mcu_mem_pkg.sv
// Shared types for the MCU external-memory port arbiter.
//   state_e : transaction sequencer states
//   owner_e : which requester owns the in-flight transaction
//   SIZE_*  : access size encodings carried on mem_size
package mcu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_LS = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin grant logic (IF vs LS).
//   clk, rst_n : clock, synchronous active-low reset
//   en_i       : grants may be issued
//   req_if_i   : IF request
//   req_ls_i   : LS request
//   upd_i      : a grant was taken; remember the winner
//   gnt_if_o   : IF granted
//   gnt_ls_o   : LS granted
module rr_arb2
  import mcu_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req_if_i,
  input  logic req_ls_i,
  input  logic upd_i,
  output logic gnt_if_o,
  output logic gnt_ls_o
);

  owner_e last_q, last_d;

  // On contention the port that did not win last time goes first.
  always_comb begin
    gnt_if_o = en_i & req_if_i & (~req_ls_i | (last_q == OWNER_LS));
    gnt_ls_o = en_i & req_ls_i & (~req_if_i | (last_q == OWNER_IF));
  end

  always_comb begin
    last_d = last_q;
    if (upd_i) last_d = gnt_if_o ? OWNER_IF : OWNER_LS;
  end

  // LS after reset so IF wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= OWNER_LS;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external-memory controller between instruction fetch (IF)
// and load/store (LS). Round-robin grant in IDLE, latch command, strobe
// mem_start, wait for mem_done (or abort after TIMEOUT_CYCLES), then
// pulse the owner's response valid.
//   if_*  : IF request / response
//   ls_*  : LS request / response
//   resp_*: shared response data/error, valid with an *_resp_valid pulse
//   mem_* : command to / completion from the memory controller
//   busy  : a transaction is in flight
module mem_port_arbiter
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_W         = 24,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  input  logic              ls_valid,
  output logic              ls_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_we,
  input  logic [31:0]       ls_wdata,
  input  logic [1:0]        ls_size,
  output logic              ls_resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_done,
  input  logic [31:0]       mem_rdata,
  output logic              mem_abort,
  output logic              busy
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [TO_W-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic gnt_if, gnt_ls, hs, timeout;

  // Grants already include valid, so a grant is a handshake.
  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (ena & (state_q == IDLE)),
    .req_if_i (if_valid),
    .req_ls_i (ls_valid),
    .upd_i    (hs),
    .gnt_if_o (gnt_if),
    .gnt_ls_o (gnt_ls)
  );

  assign hs      = gnt_if | gnt_ls;
  assign timeout = (cnt_q == TO_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_done || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    if_ready      = gnt_if;
    ls_ready      = gnt_ls;
    mem_start     = (state_q == ISSUE);
    // mem_done wins over a coincident timeout.
    mem_abort     = (state_q == WAIT) & timeout & ~mem_done;
    if_resp_valid = (state_q == RESP) & (owner_q == OWNER_IF);
    ls_resp_valid = (state_q == RESP) & (owner_q == OWNER_LS);
    busy          = (state_q != IDLE);
  end

  // Command latch, watchdog counter and response capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWNER_IF;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (hs) begin
          owner_q <= gnt_if ? OWNER_IF : OWNER_LS;
          addr_q  <= gnt_if ? if_addr  : ls_addr;
          we_q    <= gnt_if ? 1'b0     : ls_we;
          wdata_q <= gnt_if ? '0       : ls_wdata;
          size_q  <= gnt_if ? SIZE_WORD : ls_size;
        end
        ISSUE: cnt_q <= '0;
        WAIT: begin
          // Saturates at TO_MAX so it can never wrap.
          if (!timeout) cnt_q <= cnt_q + 1'b1;
          if (mem_done) begin
            rdata_q <= mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign mem_size   = size_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst_n, ena;
  logic              if_valid, if_ready, if_resp_valid;
  logic [ADDR_W-1:0] if_addr;
  logic              ls_valid, ls_ready, ls_we, ls_resp_valid;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [1:0]        ls_size;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_start, mem_we, mem_done, mem_abort, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [1:0]        mem_size;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid),
    .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_size(ls_size),
    .ls_resp_valid(ls_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_abort(mem_abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive at posedge+1, sample at posedge+2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Idle requesters; controller answers the cycle after mem_start.
  task automatic drain(input int n);
    logic sp;
    sp = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      mem_done = sp;
      #1;
      sp = mem_start;
    end
    mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       sp;
    int         ng, nrdy, lat;
    logic       found;
    logic [3:0] g_if;
    int         g_cyc [4];

    rst_n = 0; ena = 0; if_valid = 0; ls_valid = 0; if_addr = '0; ls_addr = '0;
    ls_we = 0; ls_wdata = '0; ls_size = '0; mem_done = 0; mem_rdata = '0;
    g_if = '0;
    for (int k = 0; k < 4; k++) g_cyc[k] = 0;

    // ---- reset state
    cyc(); cyc(); #1;
    chk("rst_busy",     32'(busy), 0);
    chk("rst_start",    32'(mem_start), 0);
    chk("rst_abort",    32'(mem_abort), 0);
    chk("rst_if_resp",  32'(if_resp_valid), 0);
    chk("rst_ls_resp",  32'(ls_resp_valid), 0);
    chk("rst_addr",     32'(mem_addr), 0);
    chk("rst_size",     32'(mem_size), 0);
    chk("rst_rdata",    resp_rdata, 0);
    chk("rst_err",      32'(resp_err), 0);

    // ---- contention from reset: IF, LS, IF, LS every 4 cycles
    cyc();
    rst_n = 1; ena = 1; if_valid = 1; ls_valid = 1;
    if_addr = 24'h000200; ls_addr = 24'h000300; ls_size = 2'd2;
    sp = 1'b0; ng = 0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) cyc();
      mem_done = sp;
      #1;
      chk("one_ready", 32'(if_ready & ls_ready), 0);
      if ((if_ready | ls_ready) && ng < 4) begin
        g_if[ng] = if_ready;
        g_cyc[ng] = i;
        ng++;
      end
      sp = mem_start;
    end
    chk("cont_ngrant", 32'(ng), 4);
    chk("cont_order", 32'(g_if), 32'h5);
    for (int k = 1; k < 4; k++) chk("cont_gap", 32'(g_cyc[k] - g_cyc[k-1]), 4);
    cyc(); if_valid = 0; ls_valid = 0; mem_done = 0; #1;
    chk("cont_idle", 32'(busy), 0);

    // ---- single IF read, done 3 cycles after mem_start
    cyc(); if_valid = 1; if_addr = 24'h000100; #1;
    chk("if_ready", 32'(if_ready), 1);
    chk("if_ls_ready", 32'(ls_ready), 0);
    cyc(); if_valid = 0; #1;
    chk("if_start", 32'(mem_start), 1);
    chk("if_addr", 32'(mem_addr), 32'h100);
    chk("if_we", 32'(mem_we), 0);
    chk("if_size", 32'(mem_size), 2);
    chk("if_wdata", mem_wdata, 0);
    chk("if_busy", 32'(busy), 1);
    cyc(); #1;
    chk("if_start_1cyc", 32'(mem_start), 0);
    cyc(); #1;
    cyc(); mem_done = 1; mem_rdata = 32'hDEADBEEF; #1;
    chk("if_resp_early", 32'(if_resp_valid), 0);
    cyc(); mem_done = 0; mem_rdata = '0; #1;
    chk("if_resp", 32'(if_resp_valid), 1);
    chk("if_ls_resp", 32'(ls_resp_valid), 0);
    chk("if_rdata", resp_rdata, 32'hDEADBEEF);
    chk("if_err", 32'(resp_err), 0);
    cyc(); #1;
    chk("if_resp_1cyc", 32'(if_resp_valid), 0);
    chk("if_done_idle", 32'(busy), 0);
    chk("if_rdata_hold", resp_rdata, 32'hDEADBEEF);

    // ---- LS byte write
    cyc(); ls_valid = 1; ls_addr = 24'h000040; ls_we = 1; ls_wdata = 32'hA5; ls_size = 2'd0; #1;
    chk("ls_ready", 32'(ls_ready), 1);
    chk("ls_if_ready", 32'(if_ready), 0);
    cyc(); ls_valid = 0; #1;
    chk("ls_start", 32'(mem_start), 1);
    chk("ls_addr", 32'(mem_addr), 32'h40);
    chk("ls_we", 32'(mem_we), 1);
    chk("ls_wdata", mem_wdata, 32'hA5);
    chk("ls_size", 32'(mem_size), 0);
    cyc(); mem_done = 1; #1;
    cyc(); mem_done = 0; #1;
    chk("ls_resp", 32'(ls_resp_valid), 1);
    chk("ls_if_resp", 32'(if_resp_valid), 0);
    chk("ls_err", 32'(resp_err), 0);
    cyc(); ls_we = 0; #1;

    // ---- timeout (TIMEOUT_CYCLES=4): abort on the 5th WAIT cycle
    cyc(); if_valid = 1; if_addr = 24'h000500; mem_rdata = 32'hFFFFFFFF; #1;
    chk("to_ready", 32'(if_ready), 1);
    cyc(); if_valid = 0; #1;
    chk("to_start", 32'(mem_start), 1);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      cyc(); #1;
      if (mem_abort) begin found = 1'b1; lat = i; end
    end
    chk("to_abort_seen", 32'(found), 1);
    chk("to_abort_lat", 32'(lat), 5);
    cyc(); #1;
    chk("to_abort_1cyc", 32'(mem_abort), 0);
    chk("to_resp", 32'(if_resp_valid), 1);
    chk("to_err", 32'(resp_err), 1);
    chk("to_rdata", resp_rdata, 0);
    cyc(); mem_done = 1; #1;
    chk("late_done_busy", 32'(busy), 0);
    chk("late_done_start", 32'(mem_start), 0);
    cyc(); mem_done = 0; #1;
    chk("late_done_if_resp", 32'(if_resp_valid), 0);
    chk("late_done_ls_resp", 32'(ls_resp_valid), 0);
    chk("late_done_idle", 32'(busy), 0);
    cyc(); ls_valid = 1; ls_addr = 24'h000080; ls_size = 2'd2; #1;
    chk("post_to_ready", 32'(ls_ready), 1);
    cyc(); ls_valid = 0; #1;
    chk("post_to_start", 32'(mem_start), 1);
    chk("post_to_addr", 32'(mem_addr), 32'h80);
    cyc(); mem_done = 1; mem_rdata = 32'h12345678; #1;
    chk("post_to_no_abort", 32'(mem_abort), 0);
    cyc(); mem_done = 0; #1;
    chk("post_to_resp", 32'(ls_resp_valid), 1);
    chk("post_to_rdata", resp_rdata, 32'h12345678);
    chk("post_to_err", 32'(resp_err), 0);
    cyc(); #1;

    // ---- ena gating (last grant LS)
    ena = 0; if_valid = 1; ls_valid = 1; nrdy = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      if (if_ready | ls_ready) nrdy++;
    end
    chk("ena_no_ready", 32'(nrdy), 0);
    cyc(); ena = 1; #1;
    chk("ena_if_ready", 32'(if_ready), 1);
    chk("ena_ls_ready", 32'(ls_ready), 0);
    cyc(); ena = 0; if_valid = 0; #1;
    chk("ena_start", 32'(mem_start), 1);
    chk("ena_addr", 32'(mem_addr), 32'h500);
    cyc(); mem_done = 1; mem_rdata = 32'hCAFEF00D; #1;
    cyc(); mem_done = 0; #1;
    chk("ena_off_resp", 32'(if_resp_valid), 1);
    chk("ena_off_rdata", resp_rdata, 32'hCAFEF00D);
    cyc(); #1;
    chk("ena_off_ls_ready", 32'(ls_ready), 0);
    cyc(); ena = 1; if_valid = 1; #1;
    chk("ena_rr_ls", 32'(ls_ready), 1);
    chk("ena_rr_if", 32'(if_ready), 0);

    // ---- reset while in WAIT
    cyc(); if_valid = 0; ls_valid = 0; #1;
    chk("rw_start", 32'(mem_start), 1);
    cyc(); rst_n = 0; #1;
    cyc(); rst_n = 1; #1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_start0", 32'(mem_start), 0);
    chk("rw_abort0", 32'(mem_abort), 0);
    chk("rw_if_resp", 32'(if_resp_valid), 0);
    chk("rw_ls_resp", 32'(ls_resp_valid), 0);
    chk("rw_addr", 32'(mem_addr), 0);
    cyc(); #1;
    chk("rw_ls_resp2", 32'(ls_resp_valid), 0);
    chk("rw_busy2", 32'(busy), 0);
    cyc(); if_valid = 1; ls_valid = 1; #1;
    chk("rw_if_first", 32'(if_ready), 1);
    chk("rw_ls_wait", 32'(ls_ready), 0);
    cyc(); if_valid = 0; ls_valid = 0; #1;
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
